// File: rtl/alu_branch_pkg.sv
// rtl/alu_branch_pkg.sv - shared widths, field positions and opcode/funct codes
package alu_branch_pkg;

    localparam int ADDRESS_WIDTH_DEFAULT = 5;
    localparam int DATA_SIZE_DEFAULT     = 32;
    localparam int INSTR_WIDTH           = 32;

    localparam int OPCODE_W = 6;
    localparam int REG_W    = 5;
    localparam int SHIFT_W  = 5;
    localparam int FUNCT_W  = 6;
    localparam int IMM_W    = 16;
    localparam int JUMP_W   = 26;

    localparam int OPCODE_LSB = 26;
    localparam int RS_LSB     = 21;
    localparam int RT_LSB     = 16;
    localparam int RD_LSB     = 11;
    localparam int SHIFT_LSB  = 6;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_LSB    = 0;
    localparam int JUMP_LSB   = 0;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'd0;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'd1;
    localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'd2;
    localparam logic [OPCODE_W-1:0] OP_ORI   = 6'd3;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'd4;
    localparam logic [OPCODE_W-1:0] OP_BNE   = 6'd5;
    localparam logic [OPCODE_W-1:0] OP_BGT   = 6'd6;
    localparam logic [OPCODE_W-1:0] OP_BGE   = 6'd7;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'd8;
    localparam logic [OPCODE_W-1:0] OP_JR    = 6'd9;
    localparam logic [OPCODE_W-1:0] OP_JAL   = 6'd10;
    localparam logic [OPCODE_W-1:0] OP_SLT   = 6'd11;
    localparam logic [OPCODE_W-1:0] OP_SLTI  = 6'd12;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'd13;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'd14;

    localparam logic [FUNCT_W-1:0] FN_SLL = 6'h00;
    localparam logic [FUNCT_W-1:0] FN_SRL = 6'h02;
    localparam logic [FUNCT_W-1:0] FN_SRA = 6'h03;
    localparam logic [FUNCT_W-1:0] FN_ADD = 6'h20;
    localparam logic [FUNCT_W-1:0] FN_SUB = 6'h22;
    localparam logic [FUNCT_W-1:0] FN_AND = 6'h24;
    localparam logic [FUNCT_W-1:0] FN_OR  = 6'h25;
    localparam logic [FUNCT_W-1:0] FN_XOR = 6'h26;
    localparam logic [FUNCT_W-1:0] FN_NOR = 6'h27;
    localparam logic [FUNCT_W-1:0] FN_SLT = 6'h2A;

endpackage

// File: rtl/instr_fields.sv
// rtl/instr_fields.sv - combinational split of an instruction word into its fields
module instr_fields
    import alu_branch_pkg::*;
(
    input  logic [INSTR_WIDTH-1:0] instruction,
    output logic [OPCODE_W-1:0]    opcode,
    output logic [REG_W-1:0]       rs,
    output logic [REG_W-1:0]       rt,
    output logic [REG_W-1:0]       rd,
    output logic [SHIFT_W-1:0]     shift,
    output logic [FUNCT_W-1:0]     funct,
    output logic [IMM_W-1:0]       imm,
    output logic [JUMP_W-1:0]      jump
);

    assign opcode = instruction[OPCODE_LSB +: OPCODE_W];
    assign rs     = instruction[RS_LSB     +: REG_W];
    assign rt     = instruction[RT_LSB     +: REG_W];
    assign rd     = instruction[RD_LSB     +: REG_W];
    assign shift  = instruction[SHIFT_LSB  +: SHIFT_W];
    assign funct  = instruction[FUNCT_LSB  +: FUNCT_W];
    assign imm    = instruction[IMM_LSB    +: IMM_W];
    assign jump   = instruction[JUMP_LSB   +: JUMP_W];

endmodule

// File: rtl/alu_branch_decode.sv
// rtl/alu_branch_decode.sv - decode, ALU result, conditional branch target and registered ALU result
module alu_branch_decode
    import alu_branch_pkg::*;
#(
    parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEFAULT,
    parameter int DATA_SIZE     = DATA_SIZE_DEFAULT
)
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [INSTR_WIDTH-1:0]   instruction,
    input  logic [ADDRESS_WIDTH:0]   pc,
    input  logic [DATA_SIZE-1:0]     rs_data,
    input  logic [DATA_SIZE-1:0]     rt_data,
    input  logic [DATA_SIZE-1:0]     rd_data,
    output logic [OPCODE_W-1:0]      opcode,
    output logic [REG_W-1:0]         rs,
    output logic [REG_W-1:0]         rt,
    output logic [REG_W-1:0]         rd,
    output logic [SHIFT_W-1:0]       shift,
    output logic [FUNCT_W-1:0]       funct,
    output logic [IMM_W-1:0]         imm,
    output logic [JUMP_W-1:0]        jump,
    output logic [DATA_SIZE-1:0]     alu_out,
    output logic [ADDRESS_WIDTH:0]   next_pc,
    output logic                     branch_taken,
    output logic [DATA_SIZE-1:0]     alu_q
);

    logic [DATA_SIZE-1:0] imm_sext;
    logic [DATA_SIZE-1:0] imm_zext;
    logic [DATA_SIZE-1:0] sra_result;

    instr_fields u_fields (
        .instruction (instruction),
        .opcode      (opcode),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .shift       (shift),
        .funct       (funct),
        .imm         (imm),
        .jump        (jump)
    );

    assign imm_sext   = {{(DATA_SIZE-IMM_W){imm[IMM_W-1]}}, imm};
    assign imm_zext   = {{(DATA_SIZE-IMM_W){1'b0}}, imm};
    assign sra_result = $unsigned($signed(rt_data) >>> shift);

    always_comb begin
        alu_out = '0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  alu_out = rs_data + rt_data;
                    FN_SUB:  alu_out = rs_data - rt_data;
                    FN_AND:  alu_out = rs_data & rt_data;
                    FN_OR:   alu_out = rs_data | rt_data;
                    FN_XOR:  alu_out = rs_data ^ rt_data;
                    FN_NOR:  alu_out = ~(rs_data | rt_data);
                    FN_SLL:  alu_out = rt_data << shift;
                    FN_SRL:  alu_out = rt_data >> shift;
                    FN_SRA:  alu_out = sra_result;
                    FN_SLT:  alu_out = {{(DATA_SIZE-1){1'b0}}, (rs_data < rt_data)};
                    default: alu_out = '0;
                endcase
            end
            OP_ADDI: alu_out = rs_data + imm_sext;
            OP_ANDI: alu_out = rs_data & imm_zext;
            OP_ORI:  alu_out = rs_data | imm_zext;
            OP_SLT:  alu_out = {{(DATA_SIZE-1){1'b0}}, (rs_data < rt_data)};
            OP_SLTI: alu_out = {{(DATA_SIZE-1){1'b0}}, (rs_data < imm_zext)};
            // Memory ops use rd_data as the base register, not rs_data.
            OP_LW, OP_SW: alu_out = rd_data + imm_sext;
            OP_J, OP_JR, OP_JAL: alu_out = '0;
            default: alu_out = '0;
        endcase
    end

    always_comb begin
        branch_taken = 1'b0;
        case (opcode)
            OP_BEQ:  branch_taken = (rd_data == rs_data);
            OP_BNE:  branch_taken = (rd_data != rs_data);
            OP_BGT:  branch_taken = ($signed(rd_data) >  $signed(rs_data));
            OP_BGE:  branch_taken = ($signed(rd_data) >= $signed(rs_data));
            default: branch_taken = 1'b0;
        endcase
    end

    // Only the low PC-width bits of imm form the offset, so the target wraps.
    assign next_pc = branch_taken ? (pc + imm[ADDRESS_WIDTH:0]) : pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_q <= '0;
        end else begin
            alu_q <= alu_out;
        end
    end

endmodule

// File: tb/tb_alu_branch_decode.sv
// tb/tb_alu_branch_decode.sv - directed self-checking bench for alu_branch_decode
module tb_alu_branch_decode;

    logic        clk;
    logic        rst;
    logic [31:0] instruction;
    logic [5:0]  pc;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] rd_data;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shift;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] jump;
    logic [31:0] alu_out;
    logic [5:0]  next_pc;
    logic        branch_taken;
    logic [31:0] alu_q;

    int compared;
    int mismatched;

    alu_branch_decode #(.ADDRESS_WIDTH(5), .DATA_SIZE(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .instruction  (instruction),
        .pc           (pc),
        .rs_data      (rs_data),
        .rt_data      (rt_data),
        .rd_data      (rd_data),
        .opcode       (opcode),
        .rs           (rs),
        .rt           (rt),
        .rd           (rd),
        .shift        (shift),
        .funct        (funct),
        .imm          (imm),
        .jump         (jump),
        .alu_out      (alu_out),
        .next_pc      (next_pc),
        .branch_taken (branch_taken),
        .alu_q        (alu_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] instr_r(input logic [5:0] fn, input logic [4:0] sh);
        return {6'd0, 5'd0, 5'd0, 5'd0, sh, fn};
    endfunction

    function automatic logic [31:0] instr_i(input logic [5:0] op, input logic [15:0] im);
        return {op, 5'd0, 5'd0, im};
    endfunction

    task automatic apply(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] d, input logic [5:0] p);
        @(negedge clk);
        instruction = ins;
        rs_data     = a;
        rt_data     = b;
        rd_data     = d;
        pc          = p;
        #1;
    endtask

    initial begin
        compared    = 0;
        mismatched  = 0;
        rst         = 1'b1;
        instruction = '0;
        pc          = '0;
        rs_data     = '0;
        rt_data     = '0;
        rd_data     = '0;

        @(posedge clk); #1;
        check("reset_alu_q", alu_q, 32'h0);
        rst = 1'b0;

        // Field decode
        apply({6'd0, 5'd3, 5'd4, 5'd5, 5'd6, 6'h20}, 32'd0, 32'd0, 32'd0, 6'd0);
        check("fld_opcode", 32'(opcode), 32'd0);
        check("fld_rs",     32'(rs),     32'd3);
        check("fld_rt",     32'(rt),     32'd4);
        check("fld_rd",     32'(rd),     32'd5);
        check("fld_shift",  32'(shift),  32'd6);
        check("fld_funct",  32'(funct),  32'h20);
        check("fld_imm",    32'(imm),    32'h29A0);
        check("fld_jump",   32'(jump),   32'h006429A0);

        // R-type
        apply(instr_r(6'h20, 5'd0), 32'd7, 32'd5, 32'd0, 6'd0);
        check("add_out", alu_out, 32'd12);
        @(posedge clk); #1;
        check("add_q", alu_q, 32'd12);
        apply(instr_r(6'h22, 5'd0), 32'd5, 32'd7, 32'd0, 6'd0);
        check("sub_wrap", alu_out, 32'hFFFFFFFE);
        apply(instr_r(6'h03, 5'd4), 32'd0, 32'h80000000, 32'd0, 6'd0);
        check("sra", alu_out, 32'hF8000000);
        apply(instr_r(6'h02, 5'd4), 32'd0, 32'h80000000, 32'd0, 6'd0);
        check("srl", alu_out, 32'h08000000);
        apply(instr_r(6'h00, 5'd31), 32'd0, 32'd1, 32'd0, 6'd0);
        check("sll", alu_out, 32'h80000000);
        apply(instr_r(6'h27, 5'd0), 32'hF0F0F0F0, 32'h0F0F0000, 32'd0, 6'd0);
        check("nor", alu_out, 32'h00000F0F);
        apply(instr_r(6'h26, 5'd0), 32'hFF00FF00, 32'h0FF00FF0, 32'd0, 6'd0);
        check("xor", alu_out, 32'hF0F0F0F0);
        apply(instr_r(6'h2A, 5'd0), 32'hFFFFFFFF, 32'd1, 32'd0, 6'd0);
        check("rslt_unsigned", alu_out, 32'd0);
        apply(instr_r(6'h3F, 5'd0), 32'd7, 32'd5, 32'd0, 6'd0);
        check("bad_funct", alu_out, 32'd0);

        // Immediate ALU ops
        apply(instr_i(6'd1, 16'hFFFD), 32'd10, 32'd0, 32'd0, 6'd0);
        check("addi_neg", alu_out, 32'd7);
        apply(instr_i(6'd2, 16'hFF00), 32'hFFFF1234, 32'd0, 32'd0, 6'd0);
        check("andi_zext", alu_out, 32'h00001200);
        apply(instr_i(6'd3, 16'h8001), 32'h10000000, 32'd0, 32'd0, 6'd0);
        check("ori_zext", alu_out, 32'h10008001);
        apply(instr_i(6'd11, 16'h0000), 32'd5, 32'd5, 32'd0, 6'd0);
        check("slt_equal", alu_out, 32'd0);
        apply(instr_i(6'd13, 16'hFFFC), 32'd0, 32'd0, 32'h100, 6'd0);
        check("lw_addr", alu_out, 32'h000000FC);
        apply(instr_i(6'd14, 16'h0010), 32'd0, 32'd0, 32'h20, 6'd0);
        check("sw_addr", alu_out, 32'h00000030);
        apply(instr_i(6'd15, 16'h1234), 32'd1, 32'd1, 32'd1, 6'd0);
        check("bad_opcode", alu_out, 32'd0);

        // slti then reset priority
        apply(instr_i(6'd12, 16'd4), 32'd3, 32'd0, 32'd0, 6'd0);
        check("slti_out", alu_out, 32'd1);
        @(posedge clk); #1;
        check("slti_q", alu_q, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_q", alu_q, 32'd0);
        check("rst_comb_out", alu_out, 32'd1);
        rst = 1'b0;

        // Branches
        apply(instr_i(6'd4, 16'd5), 32'd3, 32'd0, 32'd3, 6'd10);
        check("beq_taken", 32'(branch_taken), 32'd1);
        check("beq_pc", 32'(next_pc), 32'd15);
        check("beq_alu", alu_out, 32'd0);
        apply(instr_i(6'd5, 16'd5), 32'd9, 32'd0, 32'd9, 6'd10);
        check("bne_taken", 32'(branch_taken), 32'd0);
        check("bne_pc", 32'(next_pc), 32'd10);
        apply(instr_i(6'd4, 16'd4), 32'd8, 32'd0, 32'd8, 6'd62);
        check("wrap_pc", 32'(next_pc), 32'd2);
        apply(instr_i(6'd4, 16'h0041), 32'd8, 32'd0, 32'd8, 6'd1);
        check("imm_trunc_pc", 32'(next_pc), 32'd2);
        apply(instr_i(6'd6, 16'd3), 32'hFFFFFFFF, 32'd0, 32'd1, 6'd0);
        check("bgt_signed", 32'(branch_taken), 32'd1);
        check("bgt_pc", 32'(next_pc), 32'd3);
        apply(instr_i(6'd7, 16'd3), 32'd4, 32'd0, 32'd4, 6'd20);
        check("bge_equal", 32'(next_pc), 32'd23);
        apply(instr_i(6'd7, 16'd3), 32'd1, 32'd0, 32'hFFFFFFFE, 6'd20);
        check("bge_neg", 32'(branch_taken), 32'd0);
        check("bge_neg_pc", 32'(next_pc), 32'd20);
        apply(instr_i(6'd8, 16'd3), 32'd2, 32'd2, 32'd2, 6'd7);
        check("j_taken", 32'(branch_taken), 32'd0);
        check("j_pc", 32'(next_pc), 32'd7);
        check("j_alu", alu_out, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
